// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: command-side initiator for the external 16-bit
// combinational ALU. Reads operands from the internal register file, drives
// registered ALU inputs, captures the result, writes it back and returns it
// over a valid/ready response channel. Issue interval is three cycles:
// IDLE (accept) -> EXEC (ALU settles) -> RESP (handshake).
module alu_cmd_sequencer #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_ra,
  input  logic [AW-1:0] cmd_rb,
  input  logic [DW-1:0] cmd_imm,
  output logic [DW-1:0] alu_in0,
  output logic [DW-1:0] alu_in1,
  output logic [2:0]    alu_op,
  input  logic [DW-1:0] alu_out,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_zero
);

  localparam int NREG = 1 << AW;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [2:0] OP_LDI = 3'b111;

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] rf_q [NREG];
  logic [DW-1:0] rf_d [NREG];
  logic [DW-1:0] alu_in0_q, alu_in0_d;
  logic [DW-1:0] alu_in1_q, alu_in1_d;
  logic [2:0]    alu_op_q, alu_op_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [DW-1:0] imm_q, imm_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          rsp_zero_q, rsp_zero_d;

  logic [DW-1:0] opnd_a, opnd_b;
  logic [DW-1:0] result;

  // r0 is hard-wired to zero on the read side; writes to it are also dropped.
  assign opnd_a = (cmd_ra == '0) ? '0 : rf_q[cmd_ra];
  assign opnd_b = (cmd_rb == '0) ? '0 : rf_q[cmd_rb];

  // Load-immediate bypasses the ALU; every other opcode takes the ALU result.
  assign result = (alu_op_q == OP_LDI) ? imm_q : alu_out;

  assign cmd_ready = (state_q == IDLE);
  assign alu_in0   = alu_in0_q;
  assign alu_in1   = alu_in1_q;
  assign alu_op    = alu_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zero  = rsp_zero_q;

  // Next-state logic: accept, execute/writeback, then hold response until taken.
  always_comb begin
    state_d     = state_q;
    rf_d        = rf_q;
    alu_in0_d   = alu_in0_q;
    alu_in1_d   = alu_in1_q;
    alu_op_d    = alu_op_q;
    rd_d        = rd_q;
    imm_d       = imm_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_zero_d  = rsp_zero_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          alu_in0_d = opnd_a;
          alu_in1_d = opnd_b;
          alu_op_d  = cmd_op;
          rd_d      = cmd_rd;
          imm_d     = cmd_imm;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        // Writeback lands here, ahead of the response handshake, so the next
        // accepted command always reads the updated register without forwarding.
        if (rd_q != '0) begin
          rf_d[rd_q] = result;
        end
        rsp_data_d  = result;
        rsp_zero_d  = (result == '0);
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
      alu_in0_q   <= '0;
      alu_in1_q   <= '0;
      alu_op_q    <= '0;
      rd_q        <= '0;
      imm_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= rf_d[i];
      end
      alu_in0_q   <= alu_in0_d;
      alu_in1_q   <= alu_in1_d;
      alu_op_q    <= alu_op_d;
      rd_q        <= rd_d;
      imm_q       <= imm_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_zero_q  <= rsp_zero_d;
    end
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Command-side initiator for the 16-bit combinational ALU: accepts register-level commands over a valid/ready interface and reads operands from an internal register file.
- Drives the ALU's in0/in1/op from registers, captures the ALU result, writes it back to the register file and returns it over a valid/ready response channel.
- Sits between the microcontroller decode stage and the ALU. Owns the general-purpose register file.

Parameters:
- DW, 16, datapath width; must equal the ALU width.
- AW, 3, register index width; register file holds 2**AW entries.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  3  ALU opcode: 000 add, 001 sub, 010 not, 011 and, 100 or, 101 xor, 110 xnor, 111 load-immediate.
- cmd_rd  input  AW  destination register index.
- cmd_ra  input  AW  source A index (ALU in0).
- cmd_rb  input  AW  source B index (ALU in1).
- cmd_imm  input  DW  immediate, used only when cmd_op=111.
- alu_in0  output  DW  registered operand A to ALU.
- alu_in1  output  DW  registered operand B to ALU.
- alu_op  output  3  registered opcode to ALU.
- alu_out  input  DW  ALU combinational result.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_data  output  DW  result value.
- rsp_zero  output  1  rsp_data == 0.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State IDLE.
  - All register-file entries 0.
  - alu_in0, alu_in1, alu_op, rsp_data = 0; rsp_valid = 0; rsp_zero = 0; cmd_ready = 1 after release.
- Register file:
  - r0 reads as 0 always; writes to r0 are discarded.
  - Reads are combinational from the current contents.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - cmd_ready = 1.
  - On edge T0 with cmd_valid=1: alu_in0 <= R[ra], alu_in1 <= R[rb], alu_op <= cmd_op; latch rd and imm; go to EXEC.
- EXEC (one cycle):
  - cmd_ready = 0; ALU settles combinationally.
  - At edge T1, result = (op==111) ? latched imm : alu_out.
  - R[rd] <= result (unless rd=0); rsp_data <= result; rsp_zero <= (result==0); rsp_valid <= 1; go to RESP.
- RESP:
  - cmd_ready = 0.
  - rsp_valid, rsp_data and rsp_zero held stable until rsp_ready=1 at an edge.
  - At that edge rsp_valid <= 0 and state goes to IDLE.
  - rsp_data, rsp_zero and alu_* keep their last values.
- Latency and throughput:
  - Result visible on rsp_data one cycle after acceptance (rsp_valid first high after edge T1).
  - Minimum issue interval is 3 cycles with rsp_ready tied high.
- Arithmetic: modulo 2**DW; add/sub wrap silently; no carry or overflow output.
- Hazards: writeback completes at T1, before the response handshake, so the next accepted command always sees the updated register. No forwarding is needed.
- Operand aliasing: ra == rb == rd is legal. Operands are sampled at T0, the result is written at T1.
- cmd_* is ignored whenever cmd_ready = 0; no queuing.
- Reset mid-operation (EXEC or RESP): operation aborted, no writeback if before T1, rsp_valid drops immediately, all registers cleared.

Test Plan:
- Reset release, then load r1=0x1234 and r2=0x0FF0 via op 111 -> each response rsp_data equals the imm, rsp_valid high exactly one cycle after acceptance.
- ADD rd=3, ra=1, rb=2 -> alu_in0=0x1234, alu_in1=0x0FF0, alu_op=000 during EXEC; rsp_data=0x2224; then OR rd=4, ra=3, rb=0 returns 0x2224.
- SUB rd=5, ra=2, rb=1 -> rsp_data=0xFDBC (wrap). NOT ra=1 -> 0xEDCB. XNOR ra=1, rb=1 -> 0xFFFF.
- ADD rd=0, ra=1, rb=2 -> rsp_data=0x2224; then OR rd=6, ra=0, rb=0 -> rsp_data=0x0000, rsp_zero=1.
- Hold rsp_ready=0 for 5 cycles while presenting a new cmd_valid=1 -> rsp_valid/rsp_data stable, cmd_ready=0, new command not accepted until one cycle after rsp_ready=1.
- Assert rst_n=0 during EXEC of ADD rd=3 -> rsp_valid=0 at once; after release all registers read 0 (ADD rd=7, ra=3, rb=1 -> 0x0000).
